// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex segment table,
// the "all segments off" pattern and a counter-width helper.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    // Segment patterns, bit 0 = a ... bit 6 = g, active-high.
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    localparam logic [SEG_W-1:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
//   nibble : 4-bit hex digit
//   seg_c  : segments, [0]=a .. [6]=g, active-high
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_HEX[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment display driver with a framed update path.
// New digit values are accepted through valid/ready into a pending register and
// committed to the display only at a frame wrap, so a frame never mixes values.
//   clk, rst     : clock, asynchronous active-low reset
//   value_i      : NUM_DIGITS hex nibbles, digit 0 in [3:0]
//   dp_i         : per-digit decimal points, captured with value_i
//   value_valid  : producer offers value_i/dp_i
//   value_ready  : pending register empty
//   blank_lz_i   : leading-zero blanking enable
//   seg_o, dp_o  : segments (a..g) and decimal point
//   an_o         : digit enables, one-hot while active
//   frame_o      : one-cycle pulse in the first cycle of each frame
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 3000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic                    blank_lz_i,
    output logic [SEG_W-1:0]        seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = cnt_width(SCAN_DIV);
    localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);
    localparam logic        POL   = (COMMON_ANODE != 0);

    logic [CNT_W-1:0]      scan_cnt, scan_nxt_c;
    logic [IDX_W-1:0]      digit_idx, idx_nxt_c;
    logic [VAL_W-1:0]      disp_val, pend_val, disp_val_nxt_c;
    logic [NUM_DIGITS-1:0] disp_dp, pend_dp, disp_dp_nxt_c;
    logic                  pend_full, pend_full_nxt_c;
    logic                  frame_wrap_c, commit_c, accept_c;
    logic [NUM_DIGITS-1:0] upper_zero_c;
    logic [3:0]            nib_c;
    logic                  dp_sel_c, lz_sel_c, active_c;
    logic [SEG_W-1:0]      hex_seg_c, seg_nxt_c;
    logic [NUM_DIGITS-1:0] an_nxt_c;
    logic                  dp_nxt_c;

    // Scan timer, handshake and commit next-state.
    always_comb begin
        scan_nxt_c      = scan_cnt + CNT_W'(1);
        idx_nxt_c       = digit_idx;
        frame_wrap_c    = 1'b0;
        if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_nxt_c = '0;
            if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx_nxt_c    = '0;
                frame_wrap_c = 1'b1;
            end else begin
                idx_nxt_c = digit_idx + IDX_W'(1);
            end
        end
        commit_c        = frame_wrap_c && pend_full;
        accept_c        = value_valid && value_ready;
        pend_full_nxt_c = pend_full;
        if (commit_c) begin
            pend_full_nxt_c = 1'b0;
        end else if (accept_c) begin
            pend_full_nxt_c = 1'b1;
        end
        disp_val_nxt_c = commit_c ? pend_val : disp_val;
        disp_dp_nxt_c  = commit_c ? pend_dp  : disp_dp;
    end

    // Digit select and leading-zero detection on the value shown next cycle.
    // upper_zero_c[i] is set when nibble i and all more significant ones are 0.
    always_comb begin
        nib_c        = disp_val_nxt_c[3:0];
        dp_sel_c     = disp_dp_nxt_c[0];
        lz_sel_c     = 1'b0;
        upper_zero_c = '0;
        upper_zero_c[NUM_DIGITS-1] = (disp_val_nxt_c[VAL_W-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            upper_zero_c[i] = upper_zero_c[i+1] && (disp_val_nxt_c[4*i +: 4] == 4'h0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt_c == IDX_W'(i)) begin
                nib_c    = disp_val_nxt_c[4*i +: 4];
                dp_sel_c = disp_dp_nxt_c[i];
                lz_sel_c = (i != 0) && upper_zero_c[i];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nib_c),
        .seg_c  (hex_seg_c)
    );

    // Active-high output values for the next cycle; dead-time blanking first.
    always_comb begin
        active_c  = (scan_nxt_c >= CNT_W'(BLANK_CYC));
        an_nxt_c  = '0;
        seg_nxt_c = SEG_OFF;
        dp_nxt_c  = 1'b0;
        if (active_c) begin
            an_nxt_c = NUM_DIGITS'(1) << idx_nxt_c;
            if (!(blank_lz_i && lz_sel_c)) begin
                seg_nxt_c = hex_seg_c;
            end
            dp_nxt_c = dp_sel_c;
        end
    end

    // State and registered outputs; polarity applied at the flop input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt    <= '0;
            digit_idx   <= '0;
            disp_val    <= '0;
            disp_dp     <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            pend_full   <= 1'b0;
            value_ready <= 1'b1;
            an_o        <= {NUM_DIGITS{POL}};
            seg_o       <= SEG_OFF ^ {SEG_W{POL}};
            dp_o        <= POL;
            frame_o     <= 1'b0;
        end else begin
            scan_cnt    <= scan_nxt_c;
            digit_idx   <= idx_nxt_c;
            disp_val    <= disp_val_nxt_c;
            disp_dp     <= disp_dp_nxt_c;
            if (accept_c) begin
                pend_val <= value_i;
                pend_dp  <= dp_i;
            end
            pend_full   <= pend_full_nxt_c;
            value_ready <= !pend_full_nxt_c;
            an_o        <= an_nxt_c ^ {NUM_DIGITS{POL}};
            seg_o       <= seg_nxt_c ^ {SEG_W{POL}};
            dp_o        <= dp_nxt_c ^ POL;
            frame_o     <= frame_wrap_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: an active-high and a common-anode instance share
// stimulus; expected outputs come from a cycle-count based display model.
module tb_seg7_scan_driver;

    localparam int unsigned N     = 4;
    localparam int unsigned S     = 8;
    localparam int unsigned B     = 2;
    localparam int unsigned FRAME = N * S;
    localparam logic [13:0] CA_INV = 14'h3FFC;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        value_valid, blank_lz_i;
    logic        value_ready, ca_ready;
    logic [6:0]  seg_o, ca_seg;
    logic        dp_o, ca_dp;
    logic [3:0]  an_o, ca_an;
    logic        frame_o, ca_frame;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B), .COMMON_ANODE(0)) dut (
        .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .value_valid(value_valid),
        .value_ready(value_ready), .blank_lz_i(blank_lz_i), .seg_o(seg_o), .dp_o(dp_o),
        .an_o(an_o), .frame_o(frame_o)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B), .COMMON_ANODE(1)) dut_ca (
        .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .value_valid(value_valid),
        .value_ready(ca_ready), .blank_lz_i(blank_lz_i), .seg_o(ca_seg), .dp_o(ca_dp),
        .an_o(ca_an), .frame_o(ca_frame)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: t = cycles since reset release; digit/slot derive from t directly.
    int unsigned t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dpd, m_dpp;
    logic        m_full, m_lz, m_acc;
    logic [6:0]  hex_tab [16];
    logic [13:0] exp_v;

    function automatic logic [13:0] expect_out();
        int unsigned sc = t % S;
        int unsigned d  = (t / S) % N;
        logic [3:0]  an = '0;
        logic [6:0]  sg = '0;
        logic        dp = 1'b0;
        logic [15:0] hi;
        if (sc >= B) begin
            an = 4'(1 << d);
            hi = m_disp >> (4 * d);
            if (m_lz && d != 0 && hi == 16'h0) sg = 7'h00;
            else sg = hex_tab[4'(hi & 16'hF)];
            dp = m_dpd[d];
        end
        return {an, sg, dp, (t != 0 && t % FRAME == 0), !m_full};
    endfunction

    task automatic model_reset();
        t = 0; m_disp = '0; m_pend = '0; m_dpd = '0; m_dpp = '0;
        m_full = 1'b0; m_lz = 1'b0; m_acc = 1'b0;
    endtask

    // One clock: apply the transfer/commit rules with pre-edge inputs.
    task automatic tick();
        logic wrap;
        logic lz_s;
        wrap  = (t % FRAME == FRAME - 1);
        m_acc = value_valid && !m_full;
        lz_s  = blank_lz_i;
        @(posedge clk);
        if (wrap && m_full) begin
            m_disp = m_pend; m_dpd = m_dpp; m_full = 1'b0;
        end
        if (m_acc) begin
            m_pend = value_i; m_dpp = dp_i; m_full = 1'b1;
        end
        m_lz = lz_s;
        t++;
        @(negedge clk);
        exp_v = expect_out();
    endtask

    task automatic test_reset();
        value_i = 16'hFFFF; dp_i = 4'hF; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        compared += 2;
        if ({an_o, seg_o, dp_o, frame_o, value_ready} !== 14'b0000_0000000_0_0_1) begin
            mismatched++;
            $display("FAIL reset_async got %b want %b", {an_o, seg_o, dp_o, frame_o, value_ready}, 14'b0000_0000000_0_0_1);
        end
        if ({ca_an, ca_seg, ca_dp, ca_frame, ca_ready} !== 14'b1111_1111111_1_0_1) begin
            mismatched++;
            $display("FAIL reset_async_ca got %b want %b", {ca_an, ca_seg, ca_dp, ca_frame, ca_ready}, 14'b1111_1111111_1_0_1);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            compared += 2;
            if ({an_o, seg_o, dp_o, frame_o, value_ready} !== exp_v) begin
                mismatched++;
                $display("FAIL reset_scan t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o, value_ready}, exp_v);
            end
            if ({ca_an, ca_seg, ca_dp, ca_frame, ca_ready} !== (exp_v ^ CA_INV)) begin
                mismatched++;
                $display("FAIL reset_scan_ca t=%0d got %h want %h", t, {ca_an, ca_seg, ca_dp, ca_frame, ca_ready}, exp_v ^ CA_INV);
            end
            if (t >= 2 && t <= 7) begin
                compared++;
                if (an_o !== 4'b0001) begin
                    mismatched++;
                    $display("FAIL first_slot t=%0d got %b want 0001", t, an_o);
                end
            end
        end
    endtask

    task automatic test_load();
        value_i = 16'h1234; dp_i = 4'b0001; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        compared++;
        if (value_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL load_ready got %b want 0", value_ready);
        end
        for (int k = 0; k < 2 * FRAME + 4; k++) begin
            tick();
            compared += 2;
            if ({an_o, seg_o, dp_o, frame_o, value_ready} !== exp_v) begin
                mismatched++;
                $display("FAIL load t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o, value_ready}, exp_v);
            end
            if ({ca_an, ca_seg, ca_dp, ca_frame, ca_ready} !== (exp_v ^ CA_INV)) begin
                mismatched++;
                $display("FAIL load_ca t=%0d got %h want %h", t, {ca_an, ca_seg, ca_dp, ca_frame, ca_ready}, exp_v ^ CA_INV);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc_t;
        acc_t = -1;
        value_i = 16'h5678; dp_i = 4'b0010; value_valid = 1'b1;
        tick();
        value_i = 16'hABCD; dp_i = 4'b1000;
        for (int k = 0; k < 3 * FRAME && acc_t < 0; k++) begin
            if (value_valid && !m_full) acc_t = int'(t);
            tick();
            compared += 2;
            if ({an_o, seg_o, dp_o, frame_o, value_ready} !== exp_v) begin
                mismatched++;
                $display("FAIL backpressure t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o, value_ready}, exp_v);
            end
            if ({ca_an, ca_seg, ca_dp, ca_frame, ca_ready} !== (exp_v ^ CA_INV)) begin
                mismatched++;
                $display("FAIL backpressure_ca t=%0d got %h want %h", t, {ca_an, ca_seg, ca_dp, ca_frame, ca_ready}, exp_v ^ CA_INV);
            end
        end
        value_valid = 1'b0;
        compared++;
        if (acc_t < 0 || acc_t % FRAME != 0) begin
            mismatched++;
            $display("FAIL backpressure_accept_cycle got %0d want multiple of %0d", acc_t, FRAME);
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            compared += 2;
            if ({an_o, seg_o, dp_o, frame_o, value_ready} !== exp_v) begin
                mismatched++;
                $display("FAIL backpressure_drain t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o, value_ready}, exp_v);
            end
            if ({ca_an, ca_seg, ca_dp, ca_frame, ca_ready} !== (exp_v ^ CA_INV)) begin
                mismatched++;
                $display("FAIL backpressure_drain_ca t=%0d got %h want %h", t, {ca_an, ca_seg, ca_dp, ca_frame, ca_ready}, exp_v ^ CA_INV);
            end
        end
    endtask

    task automatic test_leading_zero();
        value_i = 16'h0070; dp_i = 4'b0100; value_valid = 1'b1; blank_lz_i = 1'b1;
        tick();
        value_valid = 1'b0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (k == 2 * FRAME) blank_lz_i = 1'b0;
            tick();
            compared += 2;
            if ({an_o, seg_o, dp_o, frame_o, value_ready} !== exp_v) begin
                mismatched++;
                $display("FAIL leading_zero t=%0d lz=%b got %h want %h", t, m_lz, {an_o, seg_o, dp_o, frame_o, value_ready}, exp_v);
            end
            if ({ca_an, ca_seg, ca_dp, ca_frame, ca_ready} !== (exp_v ^ CA_INV)) begin
                mismatched++;
                $display("FAIL leading_zero_ca t=%0d got %h want %h", t, {ca_an, ca_seg, ca_dp, ca_frame, ca_ready}, exp_v ^ CA_INV);
            end
        end
    endtask

    task automatic test_wrap_accept();
        for (int k = 0; k < 2 * FRAME && (m_full || t % FRAME != FRAME - 1); k++) tick();
        compared++;
        if (m_full || t % FRAME != FRAME - 1) begin
            mismatched++;
            $display("FAIL wrap_align got t=%0d full=%b want wrap cycle with empty pending", t, m_full);
        end
        value_i = 16'h9A0B; dp_i = 4'b1001; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        compared++;
        if (value_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL wrap_accept_ready got %b want 0", value_ready);
        end
        for (int k = 0; k < 2 * FRAME + 2; k++) begin
            tick();
            compared += 2;
            if ({an_o, seg_o, dp_o, frame_o, value_ready} !== exp_v) begin
                mismatched++;
                $display("FAIL wrap_accept t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o, value_ready}, exp_v);
            end
            if ({ca_an, ca_seg, ca_dp, ca_frame, ca_ready} !== (exp_v ^ CA_INV)) begin
                mismatched++;
                $display("FAIL wrap_accept_ca t=%0d got %h want %h", t, {ca_an, ca_seg, ca_dp, ca_frame, ca_ready}, exp_v ^ CA_INV);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            value_valid = ($urandom_range(0, 3) == 0);
            value_i     = 16'($urandom);
            if ($urandom_range(0, 1) == 0) value_i[15:8] = 8'h00;
            dp_i        = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz_i = ~blank_lz_i;
            tick();
            compared += 2;
            if ({an_o, seg_o, dp_o, frame_o, value_ready} !== exp_v) begin
                mismatched++;
                $display("FAIL random t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o, value_ready}, exp_v);
            end
            if ({ca_an, ca_seg, ca_dp, ca_frame, ca_ready} !== (exp_v ^ CA_INV)) begin
                mismatched++;
                $display("FAIL random_ca t=%0d got %h want %h", t, {ca_an, ca_seg, ca_dp, ca_frame, ca_ready}, exp_v ^ CA_INV);
            end
        end
        value_valid = 1'b0;
    endtask

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst = 1'b0; value_i = '0; dp_i = '0; value_valid = 1'b0; blank_lz_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_load();
        test_backpressure();
        test_leading_zero();
        test_wrap_accept();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
